// File: rtl/qspi_mem_emu.sv
// QSPI flash/PSRAM emulator: one byte-addressed bank per chip select, SPI/QPI commands,
// bus oversampled on clk_i, plus a backdoor write port for firmware preload.
module qspi_mem_emu #(
  parameter int              N_CS     = 2,
  parameter int              DEPTH    = 65536,
  parameter logic [N_CS-1:0] ROM_MASK = 2'b01,
  parameter int              DUMMY    = 6,
  localparam int             AW       = $clog2(DEPTH),
  localparam int             BW       = $clog2(N_CS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic [N_CS-1:0]   cs_n_i,
  input  logic [3:0]        sdi_i,
  output logic [3:0]        sdo_o,
  output logic [3:0]        sdo_oe_o,
  input  logic              bd_we_i,
  input  logic [BW+AW-1:0]  bd_addr_i,
  input  logic [7:0]        bd_data_i,
  output logic [N_CS-1:0]   qpi_o,
  output logic              err_o
);
  localparam int BI = (BW > 0) ? BW : 1;
  localparam int MW = BW + AW;
  localparam int CW = $clog2(N_CS + 1);
  localparam int SW = (AW > 8) ? AW : 8;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE} state_t;
  state_t state, state_n;

  logic            sck_m, sck_s, sck_d;
  logic [N_CS-1:0] cs_m, cs_s, cs_d;
  logic [3:0]      sdi_m, sdi_s;
  logic            rise, fall, cs_rise;
  logic [CW-1:0]   nlow;
  logic [BI-1:0]   sel, bank;
  logic            armed, quad, wr;
  logic [7:0]      dlen, dcnt, dsr, rd_q, rd_src;
  logic [4:0]      cnt, cnt_next, w;
  logic [SW-1:0]   sr, sr_next;
  logic [AW-1:0]   addr;
  logic [MW-1:0]   idx;
  logic            q_phase, start, ld_cmd, n_quad, n_wr, qpi_set, qpi_clr, spi_we;
  logic [7:0]      n_dlen;
  logic [7:0]      mem [N_CS*DEPTH];

  // Synchronisers are left unreset so they already track the pins when reset drops.
  always_ff @(posedge clk_i) begin
    sck_m <= sck_i;  sck_s <= sck_m;  sck_d <= sck_s;
    cs_m  <= cs_n_i; cs_s  <= cs_m;   cs_d  <= cs_s;
    sdi_m <= sdi_i;  sdi_s <= sdi_m;
  end

  assign rise    = sck_s & ~sck_d;
  assign fall    = ~sck_s & sck_d;
  assign cs_rise = |(cs_s & ~cs_d);

  always_comb begin
    nlow = '0;
    sel  = '0;
    for (int i = 0; i < N_CS; i++)
      if (!cs_s[i]) begin
        nlow = nlow + CW'(1);
        sel  = BI'(i);
      end
  end

  assign q_phase  = (state == S_CMD) ? qpi_o[bank] : quad;
  assign w        = q_phase ? 5'd4 : 5'd1;
  assign cnt_next = cnt + w;
  assign sr_next  = q_phase ? SW'({sr, sdi_s}) : SW'({sr, sdi_s[0]});
  assign idx      = MW'({bank, addr});
  assign rd_src   = (cnt == '0) ? rd_q : dsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    ld_cmd  = 1'b0;
    n_quad  = qpi_o[bank];
    n_wr    = 1'b0;
    n_dlen  = '0;
    qpi_set = 1'b0;
    qpi_clr = 1'b0;
    case (state)
      S_IDLE:
        if (armed && nlow != '0) begin
          if (nlow == CW'(1)) begin
            state_n = S_CMD;
            start   = 1'b1;
          end else begin
            state_n = S_IGNORE;
          end
        end
      S_CMD:
        if (rise && cnt_next == 5'd8) begin
          ld_cmd  = 1'b1;
          state_n = S_ADDR;
          case (sr_next[7:0])
            8'h03: n_dlen = '0;
            8'h0B: n_dlen = 8'd8;
            8'hEB: begin n_quad = 1'b1; n_dlen = 8'(DUMMY); end
            8'h02: n_wr = 1'b1;
            8'h38: begin n_quad = 1'b1; n_wr = 1'b1; end
            8'h35: begin qpi_set = 1'b1; state_n = S_IGNORE; end
            8'hF5: begin qpi_clr = 1'b1; state_n = S_IGNORE; end
            default: state_n = S_IGNORE;
          endcase
        end
      S_ADDR:
        if (rise && cnt_next == 5'd24)
          state_n = (dlen != '0) ? S_DUMMY : (wr ? S_WRITE : S_READ);
      S_DUMMY:
        if (rise && dcnt + 8'd1 == dlen) state_n = S_READ;
      default: ;
    endcase
    if (state != S_IDLE) begin
      if (cs_rise)              state_n = S_IDLE;
      else if (nlow > CW'(1))   state_n = S_IGNORE;
    end
  end

  assign spi_we = (state == S_WRITE) && (state_n == S_WRITE) && rise &&
                  (cnt_next == 5'd8) && !ROM_MASK[bank];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed    <= 1'b0;
      bank     <= '0;
      quad     <= 1'b0;
      wr       <= 1'b0;
      dlen     <= '0;
      cnt      <= '0;
      dcnt     <= '0;
      sr       <= '0;
      dsr      <= '0;
      addr     <= '0;
      sdo_o    <= '0;
      sdo_oe_o <= '0;
      qpi_o    <= '0;
      err_o    <= 1'b0;
    end else begin
      // A new transaction is only accepted after every CS has been seen high.
      if (&cs_s)                                     armed <= 1'b1;
      else if (state == S_IDLE && state_n != S_IDLE) armed <= 1'b0;
      if (nlow > CW'(1)) err_o <= 1'b1;
      if (start) bank <= sel;
      if (ld_cmd) begin
        quad <= n_quad;
        wr   <= n_wr;
        dlen <= n_dlen;
      end
      if (qpi_set) qpi_o[bank] <= 1'b1;
      if (qpi_clr) qpi_o[bank] <= 1'b0;

      if (state_n != state) begin
        cnt  <= '0;
        dcnt <= '0;
        if (state == S_ADDR) addr <= sr_next[AW-1:0];
      end else if (rise) begin
        case (state)
          S_CMD, S_ADDR: begin
            sr  <= sr_next;
            cnt <= cnt_next;
          end
          S_WRITE: begin
            sr <= sr_next;
            if (cnt_next == 5'd8) begin
              cnt  <= '0;
              addr <= addr + AW'(1);
            end else begin
              cnt <= cnt_next;
            end
          end
          S_DUMMY: dcnt <= dcnt + 8'd1;
          default: ;
        endcase
      end else if (fall && state == S_READ) begin
        cnt <= (cnt_next == 5'd8) ? '0 : cnt_next;
        dsr <= quad ? {rd_src[3:0], 4'h0} : {rd_src[6:0], 1'b0};
        if (cnt == '0) addr <= addr + AW'(1);
      end

      if (state_n != S_READ) begin
        sdo_o    <= '0;
        sdo_oe_o <= '0;
      end else if (fall && state == S_READ) begin
        sdo_o    <= quad ? rd_src[7:4] : {2'b00, rd_src[7], 1'b0};
        sdo_oe_o <= quad ? 4'hF : 4'h2;
      end
    end
  end

  // Backdoor write is issued last so it wins a same-byte collision.
  always_ff @(posedge clk_i) begin
    if (spi_we)  mem[idx]       <= sr_next[7:0];
    if (bd_we_i) mem[bd_addr_i] <= bd_data_i;
    rd_q <= mem[idx];
  end
endmodule

// File: tb/tb_qspi_mem_emu.sv
// Directed bench for qspi_mem_emu: host-side SPI/QPI driver, read-byte scoreboard
// fed by the stimulus and drained by an independent sck monitor.
module tb_qspi_mem_emu;
  localparam int N_CS = 2, DEPTH = 256, HP = 5;

  logic       clk = 1'b0, rst = 1'b1, sck = 1'b0;
  logic [1:0] cs_n = 2'b11;
  logic [3:0] sdi = 4'h0;
  logic [3:0] sdo, oe;
  logic       bd_we = 1'b0;
  logic [8:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  logic [1:0] qpi;
  logic       err;

  always #5 clk = ~clk;

  qspi_mem_emu #(.N_CS(N_CS), .DEPTH(DEPTH), .ROM_MASK(2'b01), .DUMMY(6)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_n_i(cs_n), .sdi_i(sdi),
    .sdo_o(sdo), .sdo_oe_o(oe), .bd_we_i(bd_we), .bd_addr_i(bd_addr),
    .bd_data_i(bd_data), .qpi_o(qpi), .err_o(err)
  );

  int         n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];
  logic       rd_active = 1'b0, rd_quad = 1'b0;
  logic [7:0] mon_sh = '0, mon_exp;
  int         mon_n = 0;
  logic       mon_oe_bad = 1'b0;

  // Monitor: samples the data lanes on every host sck rise inside a read window.
  always @(posedge sck) begin
    if (!rd_active) begin
      mon_n = 0;
      mon_oe_bad = 1'b0;
    end else begin
      if (oe !== (rd_quad ? 4'hF : 4'h2)) mon_oe_bad = 1'b1;
      if (rd_quad) begin mon_sh = {mon_sh[3:0], sdo};    mon_n += 4; end
      else         begin mon_sh = {mon_sh[6:0], sdo[1]}; mon_n += 1; end
      if (mon_n == 8) begin
        mon_n = 0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rd_byte: got %02h but no byte expected", mon_sh);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_sh !== mon_exp || mon_oe_bad) begin
            n_err++;
            $display("FAIL rd_byte: got %02h (oe_bad=%0b), expected %02h (oe %h)",
                     mon_sh, mon_oe_bad, mon_exp, rd_quad ? 4'hF : 4'h2);
          end
        end
        mon_oe_bad = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  task automatic sck_pulse(input logic [3:0] d);
    sdi = d;
    repeat (HP) @(negedge clk);
    sck = 1'b1;
    repeat (HP) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_units(input logic [31:0] data, input int n, input logic q);
    for (int i = 0; i < n; i++)
      if (q) sck_pulse(data[31-4*i -: 4]);
      else   sck_pulse({3'b000, data[31-i]});
  endtask

  task automatic begin_tx(input int k);
    @(negedge clk);
    cs_n[k] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_tx();
    repeat (HP) @(negedge clk);
    cs_n = 2'b11;
    sdi = 4'h0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_hdr(input int k, input logic [7:0] cmd, input logic [23:0] a,
                          input logic qc, input logic qa);
    begin_tx(k);
    send_units({cmd, 24'h0}, qc ? 2 : 8, qc);
    send_units({a, 8'h0}, qa ? 6 : 24, qa);
  endtask

  task automatic do_read(input int k, input logic [7:0] cmd, input logic [23:0] a,
                         input logic qc, input logic qd, input int nd, input int nb);
    send_hdr(k, cmd, a, qc, qc | qd);
    repeat (nd) sck_pulse(4'h0);
    rd_quad = qd;
    rd_active = 1'b1;
    repeat (nb * (qd ? 2 : 8)) sck_pulse(4'h0);
    rd_active = 1'b0;
    end_tx();
  endtask

  task automatic do_write(input int k, input logic [7:0] cmd, input logic [23:0] a,
                          input logic qc, input logic qd, input logic [31:0] data, input int n);
    send_hdr(k, cmd, a, qc, qc | qd);
    send_units(data, n, qc | qd);
    end_tx();
  endtask

  task automatic do_cmd(input int k, input logic [7:0] cmd, input logic qc);
    begin_tx(k);
    send_units({cmd, 24'h0}, qc ? 2 : 8, qc);
    end_tx();
  endtask

  task automatic bd_write(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sdo", {4'h0, sdo}, 8'h00);
    check("rst_oe",  {4'h0, oe},  8'h00);
    check("rst_qpi", {6'h0, qpi}, 8'h00);
    check("rst_err", {7'h0, err}, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    bd_write(9'h000, 8'hDE); bd_write(9'h001, 8'hAD);
    bd_write(9'h002, 8'hBE); bd_write(9'h003, 8'hEF);
    bd_write(9'h0FF, 8'h5C); bd_write(9'h121, 8'h77);

    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    do_read(0, 8'h03, 24'h000000, 1'b0, 1'b0, 0, 4);

    exp_q.push_back(8'hAD); exp_q.push_back(8'hBE);
    do_read(0, 8'h0B, 24'h000001, 1'b0, 1'b0, 8, 2);

    do_write(1, 8'h38, 24'h000010, 1'b0, 1'b1, 32'hA55A0000, 4);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    do_read(1, 8'hEB, 24'h000010, 1'b0, 1'b1, 6, 2);

    // Three nibbles: 0x12 commits at 0x20, the lone 0x3 must not reach 0x21.
    do_write(1, 8'h38, 24'h000020, 1'b0, 1'b1, 32'h12300000, 3);
    exp_q.push_back(8'h12); exp_q.push_back(8'h77);
    do_read(1, 8'h03, 24'h000020, 1'b0, 1'b0, 0, 2);

    do_write(0, 8'h02, 24'h000000, 1'b0, 1'b0, 32'h00000000, 8);
    exp_q.push_back(8'hDE);
    do_read(0, 8'h03, 24'h000000, 1'b0, 1'b0, 0, 1);

    exp_q.push_back(8'h5C); exp_q.push_back(8'hDE);
    do_read(0, 8'h03, 24'h0000FF, 1'b0, 1'b0, 0, 2);
    exp_q.push_back(8'hDE);
    do_read(0, 8'h03, 24'h123400, 1'b0, 1'b0, 0, 1);

    do_write(1, 8'h02, 24'h000030, 1'b0, 1'b0, 32'h3C000000, 8);
    exp_q.push_back(8'h3C);
    do_read(1, 8'h03, 24'h000030, 1'b0, 1'b0, 0, 1);

    do_cmd(1, 8'h35, 1'b0);
    check("qpi_set", {6'h0, qpi}, 8'h02);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    do_read(1, 8'hEB, 24'h000010, 1'b1, 1'b1, 6, 2);
    do_cmd(1, 8'hF5, 1'b1);
    check("qpi_clr", {6'h0, qpi}, 8'h00);

    @(negedge clk);
    cs_n = 2'b00;
    repeat (6) @(negedge clk);
    check("multi_cs_err", {7'h0, err}, 8'h01);
    check("multi_cs_oe",  {4'h0, oe},  8'h00);
    cs_n = 2'b11;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'hBE);
    do_read(0, 8'h03, 24'h000002, 1'b0, 1'b0, 0, 1);
    check("err_sticky", {7'h0, err}, 8'h01);

    // Reset in the middle of the second byte of a read.
    send_hdr(0, 8'h03, 24'h000000, 1'b0, 1'b0);
    exp_q.push_back(8'hDE);
    rd_quad = 1'b0;
    rd_active = 1'b1;
    repeat (12) sck_pulse(4'h0);
    rd_active = 1'b0;
    check("pre_rst_oe", {4'h0, oe}, 8'h02);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sdo", {4'h0, sdo}, 8'h00);
    check("midrst_oe",  {4'h0, oe},  8'h00);
    check("midrst_qpi", {6'h0, qpi}, 8'h00);
    check("midrst_err", {7'h0, err}, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 2'b11;
    repeat (8) @(negedge clk);
    exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
    do_read(0, 8'h03, 24'h000000, 1'b0, 1'b0, 0, 4);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
